// File: rtl/cpu_mem_arbiter.sv
// Two-master (fetch / load-store) to one memory port arbiter with a one-hot grant FSM.
// Optional ARB_ROUND_ROBIN_EN: tie-break by round robin instead of fixed data priority.
module cpu_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_pc,
    input  logic        inst_req_valid,
    output logic        inst_req_ready,
    output logic [31:0] inst_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_read,
    output logic        d_req_ready,
    output logic [31:0] d_rdata,
    output logic        d_rdata_valid,
    input  logic        d_rdata_ready,
    output logic [31:0] m_addr,
    output logic        m_write,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_read,
    input  logic        m_req_ready,
    input  logic [31:0] m_rdata,
    input  logic        m_rdata_valid,
    output logic        m_rdata_ready
);

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_IREQ  = 5'b00010,
        ST_IRESP = 5'b00100,
        ST_DREQ  = 5'b01000,
        ST_DRESP = 5'b10000
    } state_t;

    state_t state_r;
    logic   d_req_s;
    logic   grant_data_s;

    assign d_req_s = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data channel was granted last; resets to the fetch channel
    logic last_grant_r;

    // Tie-break: the master not granted last wins
    always_comb begin
        if (d_req_s && inst_req_valid) begin
            grant_data_s = ~last_grant_r;
        end else begin
            grant_data_s = d_req_s;
        end
    end

    // Remember which master was granted out of IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            if (grant_data_s) begin
                last_grant_r <= 1'b1;
            end else if (inst_req_valid) begin
                last_grant_r <= 1'b0;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed priority: data always wins a tie
    always_comb begin
        grant_data_s = d_req_s;
    end
`endif

    // Grant state machine; a dropped request keeps the state, never re-arbitrates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_data_s) begin
                        state_r <= ST_DREQ;
                    end else if (inst_req_valid) begin
                        state_r <= ST_IREQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IREQ: begin
                    if (inst_req_valid && m_req_ready) begin
                        state_r <= ST_IRESP;
                    end else begin
                        state_r <= ST_IREQ;
                    end
                end
                ST_IRESP: begin
                    if (m_rdata_valid && inst_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_IRESP;
                    end
                end
                ST_DREQ: begin
                    if (d_write && m_req_ready) begin
                        state_r <= ST_IDLE;
                    end else if (d_read && m_req_ready) begin
                        state_r <= ST_DRESP;
                    end else begin
                        state_r <= ST_DREQ;
                    end
                end
                ST_DRESP: begin
                    if (m_rdata_valid && d_rdata_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRESP;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Steer the bus per state; everything not owned by the current state is zero
    always_comb begin
        inst_req_ready = 1'b0;
        inst_data      = 32'h0000_0000;
        inst_valid     = 1'b0;
        d_req_ready    = 1'b0;
        d_rdata        = 32'h0000_0000;
        d_rdata_valid  = 1'b0;
        m_addr         = 32'h0000_0000;
        m_write        = 1'b0;
        m_wdata        = 32'h0000_0000;
        m_wstrb        = 4'b0000;
        m_read         = 1'b0;
        m_rdata_ready  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                m_read = 1'b0;
            end
            ST_IREQ: begin
                m_read         = inst_req_valid;
                m_addr         = inst_pc;
                inst_req_ready = m_req_ready;
            end
            ST_IRESP: begin
                inst_data     = m_rdata;
                inst_valid    = m_rdata_valid;
                m_rdata_ready = inst_ready;
            end
            ST_DREQ: begin
                m_addr      = d_addr;
                m_wdata     = d_wdata;
                m_wstrb     = d_wstrb;
                d_req_ready = m_req_ready;
                // A store beats a load when the core raises both
                if (d_write) begin
                    m_write = 1'b1;
                    m_read  = 1'b0;
                end else begin
                    m_read = d_read;
                end
            end
            ST_DRESP: begin
                d_rdata       = m_rdata;
                d_rdata_valid = m_rdata_valid;
                m_rdata_ready = d_rdata_ready;
            end
            default: begin
                m_read = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Two-master, one-slave memory-port arbiter placed between the multi-cycle RISC-V core and the single unified memory port. It merges the core's instruction-fetch channel and its load/store data channel onto one request/response bus, sequences each transaction through a grant state machine, and returns responses to the granted master only. It allows the core to run against a single-ported memory without changing the core's handshakes.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst_pc  in  32  fetch address from the core.
- inst_req_valid  in  1  fetch request; held until accepted.
- inst_req_ready  out  1  fetch request accepted.
- inst_data  out  32  fetched instruction.
- inst_valid  out  1  `inst_data` valid.
- inst_ready  in  1  core accepts `inst_data`.
- d_addr  in  32  word-aligned data address.
- d_write  in  1  store request; held until accepted.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte strobes.
- d_read  in  1  load request; held until accepted.
- d_req_ready  out  1  data request accepted.
- d_rdata  out  32  load data.
- d_rdata_valid  out  1  `d_rdata` valid.
- d_rdata_ready  in  1  core accepts `d_rdata`.
- m_addr  out  32  memory address.
- m_write  out  1  memory write request.
- m_wdata  out  32  memory write data.
- m_wstrb  out  4  memory write strobes.
- m_read  out  1  memory read request.
- m_req_ready  in  1  memory accepts the request.
- m_rdata  in  32  memory read data.
- m_rdata_valid  in  1  `m_rdata` valid.
- m_rdata_ready  out  1  arbiter accepts `m_rdata`.

## Operation
- Registered grant FSM with one-hot states:
  - IDLE: no grant.
  - IREQ: fetch granted, request phase.
  - IRESP: fetch granted, response phase.
  - DREQ: data granted, request phase.
  - DRESP: data granted, response phase.
- IDLE transitions:
  - Only `inst_req_valid` high: go to IREQ.
  - Only `d_read|d_write` high: go to DREQ.
  - Both high: arbitration policy decides (see Configuration).
  - Neither high: stay in IDLE.
- IREQ:
  - Drive `m_read=inst_req_valid`, `m_addr=inst_pc`, `m_write=0`, and `inst_req_ready=m_req_ready`.
  - On `m_read&m_req_ready`, go to IRESP.
- IRESP:
  - Drive `inst_data=m_rdata`, `inst_valid=m_rdata_valid`, and `m_rdata_ready=inst_ready`.
  - On `m_rdata_valid&inst_ready`, go to IDLE.
- DREQ:
  - Drive `m_addr=d_addr`, `m_wdata=d_wdata`, `m_wstrb=d_wstrb`, and `d_req_ready=m_req_ready`.
  - If `d_write` is high: `m_write=1` and `m_read=0`. Write wins if both are asserted.
  - Otherwise `m_read=d_read`.
  - On an accepted write, go to IDLE. Stores have no response phase.
  - On an accepted read, go to DRESP.
- DRESP:
  - Drive `d_rdata=m_rdata`, `d_rdata_valid=m_rdata_valid`, and `m_rdata_ready=d_rdata_ready`.
  - On handshake, go to IDLE.
- Every output not named for the current state is 0, including `m_addr`, `m_wdata`, `m_wstrb`, `inst_data` and `d_rdata`.
- The non-granted master never sees ready or valid.
- If a requester drops its valid in a request state (a protocol violation), the FSM stays in that state with `m_read`/`m_write` low. It does not re-arbitrate.
- `m_rdata_valid` arriving outside IRESP/DRESP is ignored. `m_rdata_ready` stays 0.

## Timing
- Reset: state is IDLE and every output is 0, asynchronously on `rst` low.
  - Reset deassertion is synchronised by the surrounding design.
  - Any in-flight transaction is dropped. The memory is reset together with the arbiter.
- Arbitration latency is 1 cycle. A request raised in cycle N is presented on `m_*` in cycle N+1 at the earliest.
- All handshake outputs are combinational from the FSM state and the opposing handshake input. There is no path from `m_req_ready` back to `m_read`/`m_write`.
- Back-to-back transactions have one IDLE cycle between a completed transaction and the next grant.
- A zero-wait memory gives the following minimum transaction times, counted from the IDLE cycle:
  - Fetch: 3 cycles (IDLE, IREQ, IRESP).
  - Load: 3 cycles.
  - Store: 2 cycles.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests in IDLE, the master not granted last wins.
  - A 1-bit `last_grant` register updates on entry to IREQ or DREQ. It resets to "instruction", so data wins the first tie after reset.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the data channel always wins ties.
  - No `last_grant` register exists.

## Test plan
- Fetch with zero-wait memory: `inst_pc=0x100`, memory returns `0x00500093`.
  - Required: `m_read=1` with `m_addr=0x100` one cycle after the request.
  - Required: `inst_valid=1` with `inst_data=0x00500093` in the IRESP cycle. Transaction ends in 3 cycles.
- Store: `d_addr=0x200`, `d_wdata=0xDEADBEEF`, `d_wstrb=4'b0011`, and `m_req_ready` delayed 2 cycles.
  - Required: `m_write` held with stable address, data and strobes until acceptance, then return to IDLE. `m_rdata_ready` is never asserted.
- Load with `m_rdata_valid` delayed 3 cycles: `d_rdata=0x12345678` delivered.
  - Required: `inst_valid` stays 0 throughout.
- Simultaneous fetch and load three times in a row.
  - With the macro: grants D, I, D.
  - Without the macro: D, D, D, with the fetch served only once data goes idle.
- `rst` asserted low in IRESP while `m_rdata_valid=0`.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Required: after release, a new fetch to `0x0` completes normally.
- `d_read` and `d_write` both high with `d_addr=0x40`.
  - Required: `m_write=1`, `m_read=0`, and no DRESP phase.
